// File: rtl/hd10_expand_pkg.sv
// Shared constants, the request-code type and the FSM state encoding for
// the hd10_expand thermometer-word builder.
package hd10_expand_pkg;

  localparam int WORD_W  = 32;
  localparam int NIB_W   = 4;
  localparam int NIBBLES = WORD_W / NIB_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  // Request code k: the number of low nibbles that come out all-ones.
  typedef logic [2:0] code_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/hd10_expand_if.sv
// Request/response bundle for hd10_expand.
//
// Handshake rule for both sides: a transfer happens on a rising clk edge
// where valid and ready are both high. A producer holding valid keeps its
// payload stable until that edge, and valid never waits on ready.
// Request side: in_valid/in_ready carry in_code.
// Response side: out_valid/out_ready carry out_word.
interface hd10_expand_if #(
  parameter int WORD_W = hd10_expand_pkg::WORD_W
);
  import hd10_expand_pkg::*;

  logic              in_valid;
  logic              in_ready;
  code_t             in_code;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_word;
  logic              busy;

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_word, busy
  );

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_word, busy
  );

endinterface

// File: rtl/hd10_expand_nibble_fill.sv
// One step of the expansion: nibble idx of the word for code k is all-ones
// when idx < k, otherwise all-zeros.
module hd10_nibble_fill
  import hd10_expand_pkg::*;
#(
  parameter int NIB_W = hd10_expand_pkg::NIB_W,
  parameter int IDX_W = hd10_expand_pkg::CNT_W
) (
  input  code_t            code,
  input  logic [IDX_W-1:0] idx,
  output logic [NIB_W-1:0] nib
);

  // Widen both operands so the compare never truncates either side.
  always_comb begin
    nib = '0;
    if (32'(idx) < 32'(code)) nib = '1;
  end

endmodule

// File: rtl/hd10_expand.sv
// hd10_expand: accepts a 3-bit code, builds the thermometer word one
// nibble per clock, then holds it until the consumer takes it. No bypass:
// a new code is accepted only once the previous word has left.
module hd10_expand
  import hd10_expand_pkg::*;
#(
  parameter int WORD_W = hd10_expand_pkg::WORD_W,
  parameter int NIB_W  = hd10_expand_pkg::NIB_W
) (
  input  logic             clk,
  input  logic             rst_n,
  hd10_expand_if.slave     bus,
  output state_e           dbg_state
);

  localparam int NUM_NIB = WORD_W / NIB_W;
  localparam int CW      = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  code_t             code_q;
  logic [WORD_W-1:0] word_q;
  logic [NIB_W-1:0]  nib;
  logic              last_nib;

  assign last_nib = (cnt_q == CW'(NUM_NIB - 1));

  hd10_nibble_fill #(
    .NIB_W (NIB_W),
    .IDX_W (CW)
  ) u_fill (
    .code (code_q),
    .idx  (cnt_q),
    .nib  (nib)
  );

  // State register; reset drops any word in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: accept in IDLE, fill NUM_NIB nibbles, wait for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = BUILD;
      BUILD:   if (last_nib)      state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Datapath: latch the code on acceptance, then write one nibble per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      code_q <= '0;
      word_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            code_q <= bus.in_code;
            word_q <= '0;
            cnt_q  <= '0;
          end
        end
        BUILD: begin
          word_q[int'(cnt_q)*NIB_W +: NIB_W] <= nib;
          if (last_nib) cnt_q <= '0;
          else          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode straight from the state; the word is masked outside HOLD.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == HOLD);
    bus.busy      = (state_q != IDLE);
    bus.out_word  = (state_q == HOLD) ? word_q : '0;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_hd10_expand.sv
// Directed bench for hd10_expand with a queue-based scoreboard.
module tb_hd10_expand;
  import hd10_expand_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n;
  state_e dbg_state;

  always #5 clk = ~clk;

  hd10_expand_if #(.WORD_W(W)) bus ();

  hd10_expand #(.WORD_W(W), .NIB_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_tab [8] = '{
    32'h0000_0000, 32'h0000_000F, 32'h0000_00FF, 32'h0000_0FFF,
    32'h0000_FFFF, 32'h000F_FFFF, 32'h00FF_FFFF, 32'h0FFF_FFFF
  };

  int n_vec = 0;
  int n_err = 0;

  function automatic void check(input string name, input logic [W-1:0] act,
                                input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- monitor ----------------
  int           cyc = 0;
  int           acc_n = -100;
  logic         prev_ov = 1'b0;
  logic         prev_stall = 1'b0;
  logic         prev_ohs = 1'b0;
  logic [W-1:0] prev_word = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_ov    = 1'b0;
      prev_stall = 1'b0;
      prev_ohs   = 1'b0;
    end else begin
      check("ready_valid_excl", W'(bus.in_ready & bus.out_valid), '0);
      if (!bus.out_valid) check("word_zero_when_invalid", bus.out_word, '0);
      if (prev_stall) begin
        check("hold_valid", W'(bus.out_valid), W'(1));
        check("hold_word_stable", bus.out_word, prev_word);
      end
      if (prev_ohs) check("ready_after_out_hs", W'(bus.in_ready), W'(1));
      if (bus.in_valid && bus.in_ready) acc_n = cyc;
      if (bus.out_valid && !prev_ov) check("latency", W'(cyc - acc_n - 1), W'(8));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got %h, expected no word", bus.out_word);
        end else begin
          check("out_word", bus.out_word, exp_q.pop_front());
        end
      end
      prev_ov    = bus.out_valid;
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_ohs   = bus.out_valid & bus.out_ready;
      prev_word  = bus.out_word;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int code);
    int t = 0;
    @(posedge clk); #1;
    while (!bus.in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.in_ready) begin
      check("send_timeout", W'(bus.in_ready), W'(1));
    end else begin
      bus.in_valid = 1'b1;
      bus.in_code  = 3'(code);
      exp_q.push_back(exp_tab[code]);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_queue_empty", W'(exp_q.size()), '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    int k;
    int last;
    int codes [5] = '{6, 0, 7, 2, 5};

    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ready", W'(bus.in_ready), W'(1));
    check("rst_out_valid", W'(bus.out_valid), '0);
    check("rst_busy", W'(bus.busy), '0);
    check("rst_out_word", bus.out_word, '0);
    check("rst_state", W'(dbg_state), W'(IDLE));

    // Release reset with a request already offered: first edge must accept.
    repeat (3) @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_code  = 3'd4;
    exp_q.push_back(exp_tab[4]);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("first_edge_accept_busy", W'(bus.busy), W'(1));
    check("first_edge_accept_ready", W'(bus.in_ready), '0);
    drain();

    // Single code 3, consumer always ready.
    send(3);
    drain();

    // All codes in order.
    for (int c = 0; c < 8; c++) send(c);
    drain();

    // Code 5 with a 20-cycle consumer stall.
    bus.out_ready = 1'b0;
    send(5);
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("stall_valid_seen", W'(bus.out_valid), W'(1));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("stall_word", bus.out_word, 32'h000F_FFFF);
      check("stall_in_ready", W'(bus.in_ready), '0);
      check("stall_busy", W'(bus.busy), W'(1));
    end
    bus.out_ready = 1'b1;
    drain();

    // Code 2 accepted, then in_code wiggles while in_valid stays high.
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_code  = 3'd2;
    exp_q.push_back(exp_tab[2]);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      bus.in_code = 3'(i + 3);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Reset in the middle of building code 7; the word must never appear.
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_code  = 3'd7;
    exp_q.push_back(exp_tab[7]);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("midrst_in_ready", W'(bus.in_ready), W'(1));
    check("midrst_out_valid", W'(bus.out_valid), '0);
    check("midrst_busy", W'(bus.busy), '0);
    check("midrst_out_word", bus.out_word, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(1);
    drain();

    // Sustained traffic: one acceptance every 10 cycles.
    bus.out_ready = 1'b1;
    k = 0;
    t = 0;
    last = 0;
    while (k < 5 && t < 200) begin
      @(posedge clk); #1;
      t++;
      if (bus.in_ready) begin
        if (k > 0) check("accept_spacing", W'(t - last), W'(10));
        last         = t;
        bus.in_valid = 1'b1;
        bus.in_code  = 3'(codes[k]);
        exp_q.push_back(exp_tab[codes[k]]);
        k++;
      end
    end
    check("sustained_accepts", W'(k), W'(5));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
